// File: rtl/weighted_table_arbiter.sv
// Weighted round-robin arbiter driven by a programmable slot table, with
// zero-weight slot skipping, credit forfeit on empty, and a bounded urgent override.
module weighted_table_arbiter #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int TABLE_SIZE     = 8,
  parameter int MAX_WEIGHT     = 64,
  parameter int BUF_WIDTH      = 3,
  parameter int MAX_URGENT     = 4,
  localparam int QW = $clog2(QUEUE_QUANTITY),
  localparam int TW = $clog2(TABLE_SIZE),
  localparam int WW = $clog2(MAX_WEIGHT),
  localparam int CW = BUF_WIDTH + 1,
  localparam int UW = $clog2(MAX_URGENT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enb,
  input  logic [TABLE_SIZE*WW-1:0]     pesos,
  input  logic [TABLE_SIZE*QW-1:0]     selecciones,
  input  logic [QUEUE_QUANTITY-1:0]    buf_empty,
  input  logic [QUEUE_QUANTITY*CW-1:0] fifo_counter,
  input  logic [CW-1:0]                umbral_alto,
  output logic [QW-1:0]                selector,
  output logic                         selector_enb,
  output logic                         urgente,
  output logic [TW-1:0]                slot
);

  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] credit_q, credit_d;
  logic [QW-1:0] sel_q, sel_d;
  logic [UW-1:0] urg_cnt_q, urg_cnt_d;
  logic [TW-1:0] slot_q, slot_d;
  logic [QW-1:0] selector_q, selector_d;
  logic          selector_enb_q, selector_enb_d;
  logic          urgente_q, urgente_d;

  logic [WW-1:0] tbl_weight [TABLE_SIZE];
  logic [QW-1:0] tbl_queue  [TABLE_SIZE];
  logic [CW-1:0] occupancy  [QUEUE_QUANTITY];
  logic          urg_found;
  logic [QW-1:0] urg_queue;
  logic          urg_take;
  logic [TW-1:0] slot_next;
  logic          burst_empty;

  // Table/occupancy unpacking and urgent candidate search (lowest index wins).
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    urg_found = 1'b0;
    urg_queue = '0;
    for (int i = 0; i < TABLE_SIZE; i++) begin
      tbl_weight[i] = pesos[i*WW +: WW];
      tbl_queue[i]  = selecciones[i*QW +: QW];
    end
    for (int q = 0; q < QUEUE_QUANTITY; q++) begin
      occupancy[q] = fifo_counter[q*CW +: CW];
    end
    for (int q = QUEUE_QUANTITY - 1; q >= 0; q--) begin
      if ((umbral_alto != '0) && (occupancy[q] >= umbral_alto) && !buf_empty[q]) begin
        urg_found = 1'b1;
        urg_queue = QW'(q);
      end
    end
  end

  // Urgent grants are capped so the table gets at least one cycle in MAX_URGENT+1.
  assign urg_take    = enb && (state_q != IDLE) && urg_found && (urg_cnt_q < UW'(MAX_URGENT));
  assign slot_next   = (slot_q == TW'(TABLE_SIZE - 1)) ? '0 : slot_q + 1'b1;
  assign burst_empty = buf_empty[sel_q];

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      sel_q          <= '0;
      urg_cnt_q      <= '0;
      slot_q         <= '0;
      selector_q     <= '0;
      selector_enb_q <= 1'b0;
      urgente_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      credit_q       <= credit_d;
      sel_q          <= sel_d;
      urg_cnt_q      <= urg_cnt_d;
      slot_q         <= slot_d;
      selector_q     <= selector_d;
      selector_enb_q <= selector_enb_d;
      urgente_q      <= urgente_d;
    end
  end

  // Next-state logic; an urgent grant leaves the table walk untouched.
  always_comb begin
    state_d = state_q;
    if (enb && !urg_take) begin
      case (state_q)
        IDLE:    state_d = LOAD;
        LOAD:    if (tbl_weight[slot_q] != '0) state_d = SERVE;
        SERVE:   if (burst_empty || (credit_q == WW'(1))) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Grant, credit and slot updates.
  always_comb begin
    credit_d       = credit_q;
    sel_d          = sel_q;
    slot_d         = slot_q;
    urg_cnt_d      = urg_cnt_q;
    selector_d     = selector_q;
    selector_enb_d = 1'b0;
    urgente_d      = 1'b0;
    if (enb) begin
      if (urg_take) begin
        selector_d     = urg_queue;
        selector_enb_d = 1'b1;
        urgente_d      = 1'b1;
        urg_cnt_d      = urg_cnt_q + 1'b1;
      end else begin
        urg_cnt_d = '0;
        case (state_q)
          LOAD: begin
            sel_d = tbl_queue[slot_q];
            if (tbl_weight[slot_q] == '0) slot_d = slot_next;
            else                          credit_d = tbl_weight[slot_q];
          end
          SERVE: begin
            if (!burst_empty) begin
              selector_d     = sel_q;
              selector_enb_d = 1'b1;
              credit_d       = credit_q - 1'b1;
              if (credit_q == WW'(1)) slot_d = slot_next;
            end else begin
              // Work-conserving: an empty burst queue forfeits its remaining credit.
              credit_d = '0;
              slot_d   = slot_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign selector     = selector_q;
  assign selector_enb = selector_enb_q;
  assign urgente      = urgente_q;
  assign slot         = slot_q;

  a_queue_in_range: assert property (@(posedge clk) disable iff (!rst)
    (state_q == LOAD) |-> (int'(tbl_queue[slot_q]) < QUEUE_QUANTITY));

endmodule
